// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, idle line value, FSM states.
package tx_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] TX_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Round-robin winner selection: first valid requester after ptr, searching upward with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          any
);

  logic        found;
  logic [31:0] cand;

  // Walk ptr+1 .. ptr+N (mod N) and keep the first valid candidate.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (32'(ptr) + 32'(k)) % 32'(N);
      if (!found && valid[cand[IW-1:0]]) begin
        found                 = 1'b1;
        winner[cand[IW-1:0]]  = 1'b1;
        winner_idx            = cand[IW-1:0];
      end
    end
    any = found;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one uart_tx among REQ_COUNT byte-stream requesters. The grant is round-robin and is
// held for a whole packet; a requester stalling mid-packet loses its lock after LOCK_TIMEOUT.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int REQ_COUNT    = 2,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_COUNT-1:0]      req_valid,
  input  logic [8*REQ_COUNT-1:0]    req_data,
  input  logic [REQ_COUNT-1:0]      req_last,
  output logic [REQ_COUNT-1:0]      req_ack,
  output logic [REQ_COUNT-1:0]      grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      lock_err
);

  localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  arb_state_e               state_q, state_d;
  logic [REQ_COUNT-1:0]     grant_q, grant_d;
  logic [IW-1:0]            gidx_q, gidx_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [BYTE_W-1:0]        tx_data_q, tx_data_d;
  logic                     tx_start_q, tx_start_d;
  logic [REQ_COUNT-1:0]     req_ack_q, req_ack_d;
  logic                     lock_err_q, lock_err_d;
  logic                     last_q, last_d;

  logic [REQ_COUNT-1:0]     pick_winner;
  logic [IW-1:0]            pick_idx;
  logic                     pick_any;
  logic [BYTE_W-1:0]        req_byte [REQ_COUNT];

  // Unpack the flat data bus into one byte per requester.
  for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  rr_pick #(
    .N  (REQ_COUNT),
    .IW (IW)
  ) u_rr_pick (
    .valid      (req_valid),
    .ptr        (rr_ptr_q),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // Next-state logic: grant selection, byte hand-off to uart_tx and lock timeout.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    tx_start_d = 1'b0;
    req_ack_d  = '0;
    lock_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (pick_any) begin
          grant_d = pick_winner;
          gidx_d  = pick_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (req_valid[gidx_q] && tx_done) begin
          tx_data_d  = req_byte[gidx_q];
          last_d     = req_last[gidx_q];
          tx_start_d = 1'b1;
          req_ack_d  = grant_q;
          timer_d    = '0;
          state_d    = ST_WAIT_START;
        end else if (timer_q == TIMER_LAST) begin
          // Owner stalled too long mid-packet: drop the lock so others can be served.
          lock_err_d = 1'b1;
          rr_ptr_d   = gidx_q;
          grant_d    = '0;
          timer_d    = '0;
          state_d    = ST_IDLE;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_START: begin
        // uart_tx lowers done the cycle after it samples start.
        if (!tx_done) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (last_q) begin
            rr_ptr_d = gidx_q;
            grant_d  = '0;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IW'(REQ_COUNT - 1);
      timer_q    <= '0;
      tx_data_q  <= TX_IDLE_BYTE;
      tx_start_q <= 1'b0;
      req_ack_q  <= '0;
      lock_err_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      req_ack_q  <= req_ack_d;
      lock_err_q <= lock_err_d;
      last_q     <= last_d;
    end
  end

  assign grant    = grant_q;
  assign req_ack  = req_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign lock_err = lock_err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a uart_tx model (done low 10 cycles after start),
// requester FIFO models and a byte scoreboard.
module tb_tx_arbiter;

  localparam int N  = 3;
  localparam int LT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [8*N-1:0]  req_data  = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    grant;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_done;
  logic            lock_err;

  tx_arbiter #(
    .REQ_COUNT    (N),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  // uart_tx model
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_done = (busy_cnt == 0);

  // requester FIFOs (q*) and scoreboard expectations (e*): {last, data}
  logic [8:0] q0[$], q1[$], q2[$];
  logic [8:0] e0[$], e1[$], e2[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_rise_cyc = 0;
  int lock_cnt = 0;
  int lock_delta = 0;
  int wait_pk [N];
  logic [N-1:0] lock_grant = '0;
  logic [N-1:0] prev_grant = '0;
  bit           prev_open = 0;
  logic         done_prev = 1'b1;
  logic [7:0]   log_data[$];
  logic [N-1:0] log_grant[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    case (i)
      0: begin q0.push_back({l, d}); e0.push_back({l, d}); end
      1: begin q1.push_back({l, d}); e1.push_back({l, d}); end
      default: begin q2.push_back({l, d}); e2.push_back({l, d}); end
    endcase
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while ((log_data.size() < n || grant != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(k < budget), 1);
  endtask

  task automatic wait_start(input int n, input int budget, input string tag);
    int k = 0;
    while (log_data.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(k < budget), 1);
  endtask

  // Monitor (scoreboard, contiguity, fairness) followed by requester drivers.
  always @(negedge clk) begin
    logic [8:0] ent;
    int         idx;
    int         sz;
    cyc++;
    if (rst) begin
      prev_open = 0;
      for (int j = 0; j < N; j++) wait_pk[j] = 0;
    end
    if (tx_start) begin
      idx = 0;
      for (int j = 0; j < N; j++) if (grant[j]) idx = j;
      check("ack_with_start", 32'(req_ack), 32'(grant));
      if (prev_open) check("contiguous", 32'(grant), 32'(prev_grant));
      else begin
        check("starve", 32'(wait_pk[idx] <= 2), 1);
        wait_pk[idx] = 0;
      end
      ent = '0;
      case (idx)
        0: begin sz = e0.size(); if (sz > 0) ent = e0.pop_front(); end
        1: begin sz = e1.size(); if (sz > 0) ent = e1.pop_front(); end
        default: begin sz = e2.size(); if (sz > 0) ent = e2.pop_front(); end
      endcase
      if (sz > 0) check("sb_data", 32'(tx_data), 32'(ent[7:0]));
      else check("sb_extra_byte", 32'(sz), 1);
      log_data.push_back(tx_data);
      log_grant.push_back(grant);
      if (ent[8]) begin
        for (int j = 0; j < N; j++) if (j != idx && req_valid[j]) wait_pk[j]++;
      end
      prev_grant = grant;
      prev_open  = !ent[8];
    end else if (req_ack != 0) begin
      check("ack_without_start", 32'(req_ack), 0);
    end
    if (lock_err) begin
      lock_cnt++;
      lock_delta = cyc - done_rise_cyc;
      lock_grant = grant;
      prev_open  = 0;
    end
    if (tx_done && !done_prev) done_rise_cyc = cyc;
    done_prev = tx_done;

    if (!rst) begin
      if (req_ack[0] && q0.size() > 0) void'(q0.pop_front());
      if (req_ack[1] && q1.size() > 0) void'(q1.pop_front());
      if (req_ack[2] && q2.size() > 0) void'(q2.pop_front());
    end
    req_valid[0]    = (q0.size() > 0);
    req_data[7:0]   = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    req_last[0]     = (q0.size() > 0) && q0[0][8];
    req_valid[1]    = (q1.size() > 0);
    req_data[15:8]  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    req_last[1]     = (q1.size() > 0) && q1[0][8];
    req_valid[2]    = (q2.size() > 0);
    req_data[23:16] = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
    req_last[2]     = (q2.size() > 0) && q2[0][8];
  end

  initial begin
    int total;
    int len;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 32'h0FF);
    check("rst_req_ack", 32'(req_ack), 0);
    check("rst_lock_err", 32'(lock_err), 0);
    rst = 1'b0;
    $display("step reset: outputs idle");

    // Single 3-byte packet from req0, including latency
    @(posedge clk); #1;
    log_data.delete(); log_grant.delete();
    push(0, 8'h01, 0); push(0, 8'h02, 0); push(0, 8'h03, 1);
    @(posedge clk); #1;
    check("lat_grant", 32'(grant), 32'b001);
    check("lat_no_start_yet", 32'(tx_start), 0);
    @(posedge clk); #1;
    check("lat_tx_start", 32'(tx_start), 1);
    check("lat_req_ack", 32'(req_ack), 32'b001);
    check("lat_tx_data", 32'(tx_data), 32'h01);
    wait_log(3, 2000, "t1_timeout");
    check("t1_count", 32'(log_data.size()), 3);
    check("t1_b0", 32'(log_data[0]), 32'h01);
    check("t1_b1", 32'(log_data[1]), 32'h02);
    check("t1_b2", 32'(log_data[2]), 32'h03);
    check("t1_g0", 32'(log_grant[0]), 32'b001);
    check("t1_g2", 32'(log_grant[2]), 32'b001);
    $display("step single packet: %0d bytes sent", log_data.size());

    // Both valid right after reset: req0 first
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    log_data.delete(); log_grant.delete();
    push(0, 8'hA0, 0); push(0, 8'hA1, 1);
    push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    wait_log(4, 2000, "t2_timeout");
    check("t2_count", 32'(log_data.size()), 4);
    check("t2_b0", 32'(log_data[0]), 32'hA0);
    check("t2_b1", 32'(log_data[1]), 32'hA1);
    check("t2_b2", 32'(log_data[2]), 32'hB0);
    check("t2_b3", 32'(log_data[3]), 32'hB1);
    check("t2_g1", 32'(log_grant[1]), 32'b001);
    check("t2_g2", 32'(log_grant[2]), 32'b010);
    $display("step simultaneous: %0d bytes sent", log_data.size());

    // req1 arrives mid-packet of req0
    log_data.delete(); log_grant.delete();
    push(0, 8'hC0, 0); push(0, 8'hC1, 0); push(0, 8'hC2, 1);
    wait_start(1, 2000, "t3_first_timeout");
    push(1, 8'hD0, 0); push(1, 8'hD1, 1);
    wait_log(5, 2000, "t3_timeout");
    check("t3_count", 32'(log_data.size()), 5);
    check("t3_b2", 32'(log_data[2]), 32'hC2);
    check("t3_g2", 32'(log_grant[2]), 32'b001);
    check("t3_b3", 32'(log_data[3]), 32'hD0);
    check("t3_g3", 32'(log_grant[3]), 32'b010);
    $display("step mid-packet arrival: %0d bytes sent", log_data.size());

    // req0 stalls after its first byte: lock timeout, then req1 served
    log_data.delete(); log_grant.delete();
    lock_cnt = 0;
    push(0, 8'h31, 0);
    push(1, 8'h41, 1);
    wait_log(2, 2000, "t4_timeout");
    check("t4_lock_cnt", 32'(lock_cnt), 1);
    check("t4_lock_delay", 32'(lock_delta), 17);
    check("t4_lock_grant", 32'(lock_grant), 0);
    check("t4_count", 32'(log_data.size()), 2);
    check("t4_b0", 32'(log_data[0]), 32'h31);
    check("t4_b1", 32'(log_data[1]), 32'h41);
    check("t4_g1", 32'(log_grant[1]), 32'b010);
    $display("step lock timeout: lock_err pulses=%0d", lock_cnt);

    // Reset during WAIT_DONE, then a fresh packet
    log_data.delete(); log_grant.delete();
    push(0, 8'h51, 0); push(0, 8'h52, 1);
    wait_start(1, 2000, "t5_first_timeout");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete(); e0.delete();
    push(0, 8'h61, 0); push(0, 8'h62, 1);
    @(posedge clk); #1;
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_tx_start", 32'(tx_start), 0);
    check("t5_rst_tx_data", 32'(tx_data), 32'h0FF);
    check("t5_rst_req_ack", 32'(req_ack), 0);
    rst = 1'b0;
    wait_log(3, 2000, "t5_timeout");
    check("t5_count", 32'(log_data.size()), 3);
    check("t5_b1", 32'(log_data[1]), 32'h61);
    check("t5_b2", 32'(log_data[2]), 32'h62);
    check("t5_g2", 32'(log_grant[2]), 32'b001);
    $display("step reset mid-byte: %0d bytes sent", log_data.size());

    // Random traffic from all three requesters
    log_data.delete(); log_grant.delete();
    total = 0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 4; p++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          push(i, 8'($urandom_range(0, 255)), (b == len - 1));
          total++;
        end
      end
    end
    wait_log(total, 8000, "t6_timeout");
    check("t6_count", 32'(log_data.size()), 32'(total));
    check("t6_drained", 32'(q0.size() + q1.size() + q2.size() + e0.size() + e1.size() + e2.size()), 0);
    $display("step random traffic: %0d bytes sent", log_data.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
